// File: rtl/tdm_pkg.sv
// Shared definitions for the 8:1 TDM link (receive demux and transmit side).
// Optional feature macro: TDM_DEMUX_PARITY_EN adds a ninth even-parity slot per frame.
package tdm_pkg;

    localparam int NUM_CH      = 8;
    // Slot index that carries the parity bit when parity framing is enabled.
    localparam int PARITY_SLOT = NUM_CH;

`ifdef TDM_DEMUX_PARITY_EN
    localparam int NUM_SLOTS   = PARITY_SLOT + 1;
`else
    // Without parity the frame ends just before where the parity slot would sit.
    localparam int NUM_SLOTS   = PARITY_SLOT;
`endif

    localparam int SEL_W       = $clog2(NUM_SLOTS);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    // High when data plus parity bit do not add up to an even number of ones.
    function automatic logic even_parity_err(input logic [NUM_CH-1:0] data,
                                             input logic               par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Wrapping slot counter for the TDM link: clear, load-1 and increment controls
// plus a flag on the final slot of a frame. Usable on the transmit side as well.
// Optional feature macro: TDM_DEMUX_PARITY_EN (frame length comes from tdm_pkg).
module tdm_slot_counter
    import tdm_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load1,
    input  logic             inc,
    output logic [SEL_W-1:0] cnt,
    output logic             last
);

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(NUM_SLOTS - 1);

    logic [SEL_W-1:0] cnt_d;
    logic [SEL_W-1:0] cnt_q;

    // Next count: clear wins over load-1, load-1 over increment; wraps after the last slot.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load1) begin
            cnt_d = SEL_W'(1);
        end else if (inc) begin
            cnt_d = (cnt_q == LAST_SLOT) ? '0 : cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign last = (cnt_q == LAST_SLOT);

endmodule

// File: rtl/tdm_demux8.sv
// Receive end of the 8:1 TDM link: routes serial slot k to dout[k] and presents
// one registered parallel word per complete frame, with frame-sync tracking.
// Optional feature macro: TDM_DEMUX_PARITY_EN adds a parity slot and parity_err.
module tdm_demux8
    import tdm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din,
    input  logic              din_valid,
    input  logic              frame_sync,
    output logic [NUM_CH-1:0] dout,
    output logic              dout_valid,
    output logic [SEL_W-1:0]  slot,
    output logic              locked,
`ifdef TDM_DEMUX_PARITY_EN
    output logic              parity_err,
`endif
    output logic              sync_err
);

    state_e            state_d, state_q;
    logic [NUM_CH-1:0] shadow_d, shadow_q;
    logic [NUM_CH-1:0] dout_d, dout_q;
    logic              dout_valid_d, dout_valid_q;
    logic              sync_err_d, sync_err_q;
    logic              locked_d, locked_q;
`ifdef TDM_DEMUX_PARITY_EN
    logic              parity_err_d, parity_err_q;
`endif

    logic              cnt_clr;
    logic              cnt_load1;
    logic              cnt_inc;
    logic              cnt_last;
    logic [SEL_W-1:0]  slot_cnt;

    tdm_slot_counter u_slot_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .load1 (cnt_load1),
        .inc   (cnt_inc),
        .cnt   (slot_cnt),
        .last  (cnt_last)
    );

    // Framing decisions: only valid bits move the state; pulses default low every cycle.
    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        sync_err_d   = 1'b0;
        cnt_clr      = 1'b0;
        cnt_load1    = 1'b0;
        cnt_inc      = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
        parity_err_d = 1'b0;
`endif
        if (din_valid) begin
            case (state_q)
                HUNT: begin
                    // Bits before the first frame marker are thrown away.
                    if (frame_sync) begin
                        shadow_d    = '0;
                        shadow_d[0] = din;
                        cnt_load1   = 1'b1;
                        state_d     = LOCKED;
                    end
                end
                LOCKED: begin
                    if (frame_sync && (slot_cnt != '0)) begin
                        // Marker arrived early: drop the partial frame and restart on this bit.
                        sync_err_d  = 1'b1;
                        shadow_d    = '0;
                        shadow_d[0] = din;
                        cnt_load1   = 1'b1;
                    end else if (!frame_sync && (slot_cnt == '0)) begin
                        // Expected marker missing: framing is lost, discard the bit.
                        sync_err_d  = 1'b1;
                        cnt_clr     = 1'b1;
                        state_d     = HUNT;
                    end else begin
                        cnt_inc = 1'b1;
                        // Parity slot index matches no data bit, so it never lands in shadow.
                        for (int k = 0; k < NUM_CH; k++) begin
                            if (int'(slot_cnt) == k) begin
                                shadow_d[k] = din;
                            end
                        end
                        if (cnt_last) begin
                            dout_d       = shadow_d;
                            dout_valid_d = 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
                            parity_err_d = even_parity_err(shadow_q, din);
`endif
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
        locked_d = (state_d == LOCKED);
    end

    // State, shadow and registered outputs; all clear asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            shadow_q     <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            sync_err_q   <= 1'b0;
            locked_q     <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            sync_err_q   <= sync_err_d;
            locked_q     <= locked_d;
`ifdef TDM_DEMUX_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign slot       = slot_cnt;
    assign locked     = locked_q;
    assign sync_err   = sync_err_q;
`ifdef TDM_DEMUX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_tdm_demux8.sv
// Self-checking bench for tdm_demux8: directed vector table, hand-written
// corner sequences and a randomized run against a frame-level reference model.
// Optional feature macro: TDM_DEMUX_PARITY_EN (parity slot and parity_err checks).
module tb_tdm_demux8;
    import tdm_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              din = 1'b0;
    logic              din_valid = 1'b0;
    logic              frame_sync = 1'b0;
    logic [NUM_CH-1:0] dout;
    logic              dout_valid;
    logic [SEL_W-1:0]  slot;
    logic              locked;
    logic              sync_err;
`ifdef TDM_DEMUX_PARITY_EN
    logic              parity_err;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tdm_demux8 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .dout       (dout),
        .dout_valid (dout_valid),
        .slot       (slot),
        .locked     (locked),
`ifdef TDM_DEMUX_PARITY_EN
        .parity_err (parity_err),
`endif
        .sync_err   (sync_err)
    );

    typedef struct {
        logic       v;
        logic       d;
        logic       fs;
        logic [7:0] e_dout;
        logic       e_dv;
        int         e_slot;
        logic       e_lk;
        logic       e_err;
    } vec_t;

    vec_t tbl[$];

    // Reference model state: bits of the frame being collected, lock flag, expectations.
    logic mq[$];
    logic       m_locked;
    logic [7:0] m_dout;
    logic       m_dv;
    logic       m_err;
    logic       m_perr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] e_dout, input logic e_dv,
                             input int e_slot, input logic e_lk, input logic e_err);
        check({tag, ".dout"},       32'(dout),       32'(e_dout));
        check({tag, ".dout_valid"}, 32'(dout_valid), 32'(e_dv));
        check({tag, ".slot"},       32'(slot),       32'(e_slot));
        check({tag, ".locked"},     32'(locked),     32'(e_lk));
        check({tag, ".sync_err"},   32'(sync_err),   32'(e_err));
    endtask

    function automatic void add(input logic v, input logic d, input logic fs,
                                input logic [7:0] e_dout, input logic e_dv, input int e_slot,
                                input logic e_lk, input logic e_err);
        vec_t t;
        t.v = v; t.d = d; t.fs = fs;
        t.e_dout = e_dout; t.e_dv = e_dv; t.e_slot = e_slot; t.e_lk = e_lk; t.e_err = e_err;
        tbl.push_back(t);
    endfunction

    // One clock of stimulus: drive on the falling edge, return just after the rising edge.
    task automatic drive(input logic v, input logic d, input logic fs);
        @(negedge clk);
        din_valid  = v;
        din        = d;
        frame_sync = fs;
        @(posedge clk);
        #1;
    endtask

    // Bit sent in frame position k for data word w (position NUM_CH is the parity bit).
    function automatic logic frame_bit(input logic [7:0] w, input int k);
        if (k < NUM_CH) return w[k];
        return ^w;
    endfunction

    // Frame-level model: a frame is the list of bits collected since the marker.
    function automatic void model_step(input logic v, input logic d, input logic fs);
        m_dv = 1'b0; m_err = 1'b0; m_perr = 1'b0;
        if (!v) return;
        if (!m_locked) begin
            if (fs) begin
                m_locked = 1'b1;
                mq.delete();
                mq.push_back(d);
            end
        end else if (fs && mq.size() != 0) begin
            m_err = 1'b1;
            mq.delete();
            mq.push_back(d);
        end else if (!fs && mq.size() == 0) begin
            m_err = 1'b1;
            m_locked = 1'b0;
        end else begin
            mq.push_back(d);
            if (mq.size() == NUM_SLOTS) begin
                logic x;
                x = 1'b0;
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (i < NUM_CH) m_dout[i] = mq[i];
                    x = x ^ mq[i];
                end
                m_perr = x;
                m_dv = 1'b1;
                mq.delete();
            end
        end
    endfunction

    initial begin
        logic [7:0] words [2];
        logic [7:0] hold;
        int         pulses;
        int         pos;
        logic       v, d, fs;

        // Reset state while rst_n is held low.
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 8'h00, 1'b0, 0, 1'b0, 1'b0);
`ifdef TDM_DEMUX_PARITY_EN
        check("reset.parity_err", 32'(parity_err), 32'(0));
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table: basic 8'hAA frame, idle hold, missing sync, hunt discard.
        add(1, 0, 1, 8'h00, 0, 1, 1, 0);
        add(1, 1, 0, 8'h00, 0, 2, 1, 0);
        add(1, 0, 0, 8'h00, 0, 3, 1, 0);
        add(1, 1, 0, 8'h00, 0, 4, 1, 0);
        add(1, 0, 0, 8'h00, 0, 5, 1, 0);
        add(1, 1, 0, 8'h00, 0, 6, 1, 0);
        add(1, 0, 0, 8'h00, 0, 7, 1, 0);
`ifdef TDM_DEMUX_PARITY_EN
        add(1, 1, 0, 8'h00, 0, 8, 1, 0);
        add(1, 0, 0, 8'hAA, 1, 0, 1, 0);
`else
        add(1, 1, 0, 8'hAA, 1, 0, 1, 0);
`endif
        add(0, 1, 1, 8'hAA, 0, 0, 1, 0);
        add(1, 1, 0, 8'hAA, 0, 0, 0, 1);
        add(1, 0, 0, 8'hAA, 0, 0, 0, 0);
        add(1, 1, 0, 8'hAA, 0, 0, 0, 0);
        add(0, 0, 1, 8'hAA, 0, 0, 0, 0);
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].fs);
            check_all($sformatf("vec%0d", i), tbl[i].e_dout, tbl[i].e_dv,
                      tbl[i].e_slot, tbl[i].e_lk, tbl[i].e_err);
`ifdef TDM_DEMUX_PARITY_EN
            check($sformatf("vec%0d.parity_err", i), 32'(parity_err), 32'(0));
`endif
        end

        // Back-to-back frames 8'hAA then 8'hCC with idle gaps inside the frames.
        words[0] = 8'hAA;
        words[1] = 8'hCC;
        hold   = 8'hAA;
        pulses = 0;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
                if ($urandom_range(0, 2) == 0) begin
                    drive(1'b0, 1'($urandom), 1'($urandom));
                    check($sformatf("b2b.gap%0d_%0d.dout", f, k), 32'(dout), 32'(hold));
                    check($sformatf("b2b.gap%0d_%0d.dv", f, k), 32'(dout_valid), 32'(0));
                end
                drive(1'b1, frame_bit(words[f], k), (k == 0));
                if (dout_valid === 1'b1) pulses++;
                if (k == NUM_SLOTS - 1) begin
                    hold = words[f];
                    check($sformatf("b2b.f%0d.dout", f), 32'(dout), 32'(words[f]));
                    check($sformatf("b2b.f%0d.dv", f), 32'(dout_valid), 32'(1));
                end else begin
                    check($sformatf("b2b.f%0d_%0d.dout", f, k), 32'(dout), 32'(hold));
                end
            end
        end
        drive(1'b0, 1'b0, 1'b0);
        check("b2b.pulses", 32'(pulses), 32'(2));
        check("b2b.hold", 32'(dout), 32'(8'hCC));

        // Early sync at slot 4: error pulse, frame dropped, new frame starts on that bit.
        drive(1'b1, 1'b0, 1'b1);
        for (int k = 1; k < 4; k++) drive(1'b1, 1'b0, 1'b0);
        check("early.pre_slot", 32'(slot), 32'(4));
        drive(1'b1, 1'b1, 1'b1);
        check_all("early.sync", 8'hCC, 1'b0, 1, 1'b1, 1'b1);
        for (int k = 1; k < NUM_SLOTS; k++) begin
            drive(1'b1, frame_bit(8'h01, k), 1'b0);
            if (k < NUM_SLOTS - 1)
                check($sformatf("early.k%0d.dv", k), 32'(dout_valid), 32'(0));
        end
        check_all("early.frame", 8'h01, 1'b1, 0, 1'b1, 1'b0);
`ifdef TDM_DEMUX_PARITY_EN
        check("early.parity_err", 32'(parity_err), 32'(0));
`endif

        // Asynchronous reset mid-frame: outputs clear before any clock edge.
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_all("async_rst", 8'h00, 1'b0, 0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 1'b0);
        check_all("post_rst", 8'h00, 1'b0, 0, 1'b0, 1'b0);

`ifdef TDM_DEMUX_PARITY_EN
        // Parity mismatch: 8'hAA with parity bit 1.
        for (int k = 0; k < NUM_CH; k++) drive(1'b1, words[0][k], (k == 0));
        drive(1'b1, 1'b1, 1'b0);
        check_all("par_bad", 8'hAA, 1'b1, 0, 1'b1, 1'b0);
        check("par_bad.parity_err", 32'(parity_err), 32'(1));
        drive(1'b0, 1'b0, 1'b0);
        check("par_bad.pulse_end", 32'(parity_err), 32'(0));
`endif

        // Randomized run against the reference model.
        @(negedge clk);
        rst_n = 1'b0;
        din_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        m_locked = 1'b0;
        m_dout   = 8'h00;
        pos      = 0;
        for (int c = 0; c < 1500; c++) begin
            v  = ($urandom_range(0, 3) != 0);
            d  = 1'($urandom);
            fs = 1'b0;
            if (v) begin
                fs  = (pos == 0);
                if ($urandom_range(0, 19) == 0) fs = ~fs;
                pos = (pos + 1) % NUM_SLOTS;
            end
            drive(v, d, fs);
            model_step(v, d, fs);
            check_all($sformatf("rnd%0d", c), m_dout, m_dv,
                      m_locked ? mq.size() : 0, m_locked, m_err);
`ifdef TDM_DEMUX_PARITY_EN
            check($sformatf("rnd%0d.parity_err", c), 32'(parity_err), 32'(m_perr & m_dv));
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tdm_demux8.md
Name: tdm_demux8

Overview:
- Receive end of the 8:1 TDM link; the transmit end is the 8:1 mux driven by a rotating select.
- Takes a serial bit stream plus frame marker and routes each slot to its channel bit.
- Presents a registered 8-bit parallel word per complete frame.
- Slot k maps to dout[k]. This matches the transmit mux, where sel=k drives in[k].

Parameters:
- NUM_CH, 8, number of channels/slots per frame (fixed at 8 for this release).
- SEL_W, 3, slot counter width, equal to clog2(NUM_CH).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  1  serial slot data.
- din_valid  input  1  din carries a slot bit this cycle.
- frame_sync  input  1  qualified by din_valid; marks slot 0 of a frame.
- dout  output  NUM_CH  last complete frame, registered.
- dout_valid  output  1  one-cycle pulse; new frame on dout.
- slot  output  SEL_W  slot index expected for the next valid bit.
- locked  output  1  high in LOCKED state.
- sync_err  output  1  one-cycle pulse on framing violation.

Behaviour:
- Reset (async assert, sync release): state=HUNT, slot=0, shadow=0, dout=0, dout_valid=0, sync_err=0, locked=0.
- All state changes only on cycles with din_valid=1. With din_valid=0 everything holds, and dout_valid/sync_err drop to 0.
- HUNT:
  - Valid bits without frame_sync are discarded.
  - On din_valid&frame_sync: shadow[0]=din, slot=1, go LOCKED.
- LOCKED, normal bit (frame_sync=0 with slot!=0, or frame_sync=1 with slot==0): shadow[slot]=din, slot=slot+1.
- LOCKED, last bit (slot==NUM_CH-1):
  - dout <= {din, shadow[NUM_CH-2:0]}.
  - dout_valid=1 for one cycle.
  - slot wraps to 0.
  - Latency: dout/dout_valid visible on the cycle after the edge that samples slot 7.
- LOCKED, early sync (frame_sync=1 with slot!=0):
  - sync_err pulse; the partial frame is dropped and dout is unchanged.
  - Current bit becomes slot 0 (shadow cleared, shadow[0]=din); slot=1; stay LOCKED.
- LOCKED, missing sync (frame_sync=0 with slot==0): sync_err pulse, bit discarded, go HUNT, locked=0.
- Back-to-back frames are allowed: slot-7 bit followed directly by the next slot-0 bit. No bubble is required, and dout_valid may pulse every 8 valid cycles.
- dout holds its value between frames.
- Reset mid-frame aborts the frame. No dout_valid is produced.
- Outputs are never X after reset.

Optional Feature:
- Macro: TDM_DEMUX_PARITY_EN.
- Defined:
  - Each frame carries a 9th slot (index 8) holding even parity over the 8 data bits; SEL_W internally becomes 4.
  - The frame completes on the parity slot, not on slot 7.
  - Port parity_err (output, 1) pulses together with dout_valid when the parity mismatches.
  - dout is still updated on a parity mismatch.
  - Missing/early sync rules apply with 9 slots.
- Undefined: no parity_err port; 8-slot frames as above.

Decomposition:
- Package tdm_pkg holds:
  - NUM_CH, SEL_W.
  - State enum {HUNT, LOCKED}.
  - Constant PARITY_SLOT=NUM_CH.
- One natural sub-module, tdm_slot_counter: the wrapping slot counter with clear/load-1/increment controls and a last-slot flag. Also reusable by the transmit side.
- The FSM and shadow/dout registers stay in tdm_demux8.

Test Plan:
- Reset: assert rst_n=0 mid-stream -> dout=8'h00, dout_valid=0, slot=0, locked=0 immediately, without waiting for a clock edge.
- Basic frame:
  - Stimulus: sync at slot 0, din bits slot0..7 = 0,1,0,1,0,1,0,1.
  - Response: dout=8'hAA, one-cycle dout_valid, locked=1.
- Back-to-back frames with din_valid gaps:
  - Stimulus: frame 8'hAA then 8'hCC (slots 0..7 = 0,0,1,1,0,0,1,1), din_valid=0 on random cycles inside frames.
  - Response: dout=8'hAA then 8'hCC; exactly two dout_valid pulses; dout holds through the gaps.
- Early sync:
  - Stimulus: frame_sync at slot 4.
  - Response: sync_err pulse, no dout_valid, slot=1 after, and the following 7 bits complete a new frame with that bit in dout[0].
- Missing sync: send the slot-0 bit of the second frame without frame_sync -> sync_err pulse, locked=0, later bits ignored until the next frame_sync.
- Parity (TDM_DEMUX_PARITY_EN):
  - Data 8'hAA with parity bit 0 -> parity_err=0.
  - Data 8'hAA with parity bit 1 -> parity_err pulses with dout_valid, dout=8'hAA.
